// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer bundle for sync_fifo_ctrl.
//   master : drives wdata, winc, rinc, flush, clr_err; observes the status and data outputs
//   slave  : the FIFO itself
//
// Handshake: a write transfers on a rising edge where winc=1 and wfull=0, and a read
// transfers where rinc=1 and rempty=0. flush=1 cancels both transfers for that edge.
// wfull/rempty play the role of the inverse ready, and the FIFO never stalls a transfer
// it has already accepted.
interface sync_fifo_ctrl_if #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
);
  logic [DSIZE-1:0] wdata;
  logic             winc;
  logic             rinc;
  logic             flush;
  logic             clr_err;
  logic [DSIZE-1:0] rdata;
  logic             wfull;
  logic             rempty;
  logic             walmost_full;
  logic             ralmost_empty;
  logic [ASIZE:0]   wcount;
  logic             overflow;
  logic             underflow;

  modport master (
    output wdata, winc, rinc, flush, clr_err,
    input  rdata, wfull, rempty, walmost_full, ralmost_empty, wcount, overflow, underflow
  );

  modport slave (
    input  wdata, winc, rinc, flush, clr_err,
    output rdata, wfull, rempty, walmost_full, ralmost_empty, wcount, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with an occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, a synchronous flush and an optional
// first-word-fall-through read port.
// Ports:
//   clk : rising-edge clock for all logic
//   rst : synchronous active-high reset, which has priority over every other input
//   bus : sync_fifo_ctrl_if.slave (wdata/winc/rinc/flush/clr_err in; rdata and status out)
module sync_fifo_ctrl #(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 4,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  logic            clk,
  input  logic            rst,
  sync_fifo_ctrl_if.slave bus
);
  localparam int PTR_W = ASIZE + 1;
  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem [DEPTH];

  // The pointers carry one extra bit so that full and empty can be told apart.
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wcount_q, wcount_d;
  logic [DSIZE-1:0] rdata_q, rdata_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full, empty, wr_acc, rd_acc;
  logic [ASIZE-1:0] waddr, raddr;

  always_comb begin
    waddr  = wptr_q[ASIZE-1:0];
    raddr  = rptr_q[ASIZE-1:0];
    full   = (wptr_q[ASIZE] != rptr_q[ASIZE]) && (waddr == raddr);
    empty  = (wptr_q == rptr_q);
    // When the FIFO is full, a simultaneous read still goes through and only the write
    // is refused. When it is empty, only the write goes through.
    wr_acc = bus.winc && !full  && !bus.flush;
    rd_acc = bus.rinc && !empty && !bus.flush;
  end

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    wcount_d    = wcount_q;
    rdata_d     = rdata_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.flush) begin
      // A flush empties the FIFO and cancels any transfer requested on the same edge.
      // Because nothing was attempted, the error flags stay as they are.
      wptr_d   = '0;
      rptr_d   = '0;
      wcount_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PTR_W'(1);
      if (rd_acc) begin
        rptr_d  = rptr_q + PTR_W'(1);
        rdata_d = mem[raddr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   wcount_d = wcount_q + PTR_W'(1);
        2'b01:   wcount_d = wcount_q - PTR_W'(1);
        default: wcount_d = wcount_q;
      endcase
      // Setting a flag takes priority over clearing it on the same edge.
      if (bus.winc && full)       overflow_d  = 1'b1;
      else if (bus.clr_err)       overflow_d  = 1'b0;
      if (bus.rinc && empty)      underflow_d = 1'b1;
      else if (bus.clr_err)       underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      wcount_q    <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      wcount_q    <= wcount_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage has no reset. The pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[waddr] <= bus.wdata;
  end

  // In first-word-fall-through mode the head entry is shown directly on rdata. Its
  // value is meaningless while the FIFO is empty.
  assign bus.rdata         = (FWFT != 0) ? mem[raddr] : rdata_q;
  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.wcount        = wcount_q;
  assign bus.walmost_full  = (wcount_q >= PTR_W'(AFULL_TH));
  assign bus.ralmost_empty = (wcount_q <= PTR_W'(AEMPTY_TH));
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Bench for sync_fifo_ctrl. One instance uses a registered read port (FWFT=0) and the
// other uses first-word-fall-through (FWFT=1). Both receive the same stimulus and are
// compared against one queue-based reference model.
module tb_sync_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst, winc, rinc, flush, clr_err;
  logic [7:0] wdata;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the stored words as a plain queue, plus the sticky flags.
  logic [7:0] mdl_q[$];
  logic       m_ovf, m_unf;
  logic [7:0] m_rdata0;
  // Scoreboard: words the registered-read instance owes to the monitor.
  logic [7:0] exp_q[$];
  logic       mon_en  = 1'b0;
  logic       rd_pend = 1'b0;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DSIZE(8), .ASIZE(4)) if0 ();
  sync_fifo_ctrl_if #(.DSIZE(8), .ASIZE(4)) if1 ();

  assign if0.wdata = wdata;  assign if1.wdata = wdata;
  assign if0.winc  = winc;   assign if1.winc  = winc;
  assign if0.rinc  = rinc;   assign if1.rinc  = rinc;
  assign if0.flush = flush;  assign if1.flush = flush;
  assign if0.clr_err = clr_err;  assign if1.clr_err = clr_err;

  sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(2))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  sync_fifo_ctrl #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(2))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  // ---------------- checking helpers ----------------
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_flags(string p, logic wf, logic re, logic af, logic ae,
                                    logic [4:0] wc, logic ov, logic un);
    int n;
    n = mdl_q.size();
    chk({p, ".wfull"},         {31'd0, wf}, {31'd0, n == 16});
    chk({p, ".rempty"},        {31'd0, re}, {31'd0, n == 0});
    chk({p, ".walmost_full"},  {31'd0, af}, {31'd0, n >= 12});
    chk({p, ".ralmost_empty"}, {31'd0, ae}, {31'd0, n <= 2});
    chk({p, ".wcount"},        {27'd0, wc}, n);
    chk({p, ".overflow"},      {31'd0, ov}, {31'd0, m_ovf});
    chk({p, ".underflow"},     {31'd0, un}, {31'd0, m_unf});
  endfunction

  // Applies the effect of one rising edge to the reference model.
  function automatic void model_edge();
    logic full, empty;
    if (rst) begin
      mdl_q.delete();
      m_ovf = 1'b0;  m_unf = 1'b0;  m_rdata0 = 8'h00;
    end else if (flush) begin
      mdl_q.delete();
    end else begin
      full  = (mdl_q.size() == 16);
      empty = (mdl_q.size() == 0);
      if (winc && full)  m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
      if (rinc && empty) m_unf = 1'b1; else if (clr_err) m_unf = 1'b0;
      if (rinc && !empty) begin
        m_rdata0 = mdl_q.pop_front();
        exp_q.push_back(m_rdata0);
      end
      if (winc && !full) mdl_q.push_back(wdata);
    end
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic w, input logic [7:0] d,
                      input logic rd, input logic f, input logic c);
    rst = r;  winc = w;  wdata = d;  rinc = rd;  flush = f;  clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk_flags("d0", if0.wfull, if0.rempty, if0.walmost_full, if0.ralmost_empty,
                if0.wcount, if0.overflow, if0.underflow);
      chk_flags("d1", if1.wfull, if1.rempty, if1.walmost_full, if1.ralmost_empty,
                if1.wcount, if1.overflow, if1.underflow);
      if (rd_pend) begin
        if (exp_q.size() == 0) begin
          n_checks++;  n_errors++;
          $display("FAIL d0.read_underrun: got read %0h expected no read", if0.rdata);
        end else begin
          chk("d0.rdata", {24'd0, if0.rdata}, {24'd0, exp_q.pop_front()});
        end
      end else begin
        chk("d0.rdata_hold", {24'd0, if0.rdata}, {24'd0, m_rdata0});
      end
      if (mdl_q.size() != 0) chk("d1.rdata_fwft", {24'd0, if1.rdata}, {24'd0, mdl_q[0]});
      rd_pend <= rinc && !rst && !flush && !if0.rempty;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int pw, pr;
    step(1, 0, 8'h00, 0, 0, 0);
    mon_en = 1'b1;
    step(1, 0, 8'h00, 0, 0, 0);

    // Fill to full, then write once more while full.
    for (int i = 0; i < 16; i++) step(0, 1, 8'(i), 0, 0, 0);
    step(0, 1, 8'hAA, 0, 0, 0);
    // Drain everything, then read on empty.
    for (int i = 0; i < 16; i++) step(0, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1);
    step(0, 0, 8'h00, 1, 0, 1);
    step(0, 0, 8'h00, 0, 0, 1);

    // Move the pointers around the end of the buffer.
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h40 + i), 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'(8'h60 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++)  step(0, 0, 8'h00, 1, 0, 0);
    // Simultaneous read and write at an occupancy of 5.
    for (int i = 0; i < 20; i++) step(0, 1, 8'(8'h80 + i), 1, 0, 0);

    // Flush with requests on the same edge, then write once into the empty FIFO.
    step(0, 1, 8'h11, 1, 1, 0);
    step(0, 1, 8'h3C, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 1, 8'h5A, 0, 0, 0);
    step(0, 0, 8'h00, 1, 1, 0);

    // Random traffic in phases that favour filling first and then draining.
    for (int i = 0; i < 600; i++) begin
      pw = ((i / 75) % 2 == 0) ? 75 : 30;
      pr = ((i / 75) % 2 == 0) ? 30 : 75;
      if ($urandom_range(0, 39) == 0)
        step(0, $urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr, 1, 0);
      else if ($urandom_range(0, 249) == 0)
        step(1, 0, 8'h00, 0, 0, 0);
      else
        step(0, $urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr, 0,
             $urandom_range(0, 15) == 0);
    end

    step(0, 0, 8'h00, 0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
